// File: rtl/reg_writeback_if.sv
// reg_writeback_if: producer handshakes, hold control and register-file write/status signals
interface reg_writeback_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
);
   logic                       alu_valid;
   logic                       alu_ready;
   logic [ADDR_W-1:0]          alu_addr;
   logic [DATA_W-1:0]          alu_data;
   logic                       mem_valid;
   logic                       mem_ready;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_data;
   logic                       hold;
   logic [DATA_W-1:0]          C;
   logic [ADDR_W-1:0]          Caddr;
   logic                       Load;
   logic [2**ADDR_W-1:0]       pending;
   logic [$clog2(DEPTH):0]     count;
   logic                       full;
   logic                       empty;
   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
      output alu_ready, mem_ready, C, Caddr, Load, pending, count, full, empty
   );
   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
      input  alu_ready, mem_ready, C, Caddr, Load, pending, count, full, empty
   );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: in-order write FIFO (load unit over ALU) draining onto the register file port
module reg_writeback #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             clear,
   reg_writeback_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0]    r_addr [DEPTH];
   logic [DATA_W-1:0]    r_data [DEPTH];
   logic [PW-1:0]        r_wp, r_rp;
   logic [CW-1:0]        r_cnt;
   logic                 r_load;
   logic [DATA_W-1:0]    r_c;
   logic [ADDR_W-1:0]    r_caddr;
   logic                 w_full, w_empty, w_alu_ready, w_push, w_pop;
   logic [ADDR_W-1:0]    w_waddr;
   logic [DATA_W-1:0]    w_wdata;
   logic [PW-1:0]        w_off;
   logic [2**ADDR_W-1:0] w_pending;
   assign w_full      = r_cnt == CW'(DEPTH);
   assign w_empty     = r_cnt == '0;
   assign w_alu_ready = !w_full && !bus.mem_valid;
   assign w_push      = (bus.mem_valid && !w_full) || (bus.alu_valid && w_alu_ready);
   assign w_pop       = !bus.hold && !w_empty;
   assign w_waddr     = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
   assign w_wdata     = bus.mem_valid ? bus.mem_data : bus.alu_data;
   always_ff @(posedge clk) begin
      if (clear) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_load  <= 1'b0;
         r_c     <= '0;
         r_caddr <= '0;
      end else begin
         if (w_push) begin
            r_addr[r_wp] <= w_waddr;
            r_data[r_wp] <= w_wdata;
            r_wp         <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_c     <= r_data[r_rp];
            r_caddr <= r_addr[r_rp];
            r_rp    <= r_rp + 1'b1;
         end
         r_load <= w_pop;
         r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
   always_comb begin
      w_pending = '0;
      w_off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = PW'(i) - r_rp;
         if ({1'b0, w_off} < r_cnt) w_pending[r_addr[i]] = 1'b1;
      end
      if (r_load) w_pending[r_caddr] = 1'b1;
   end
   assign bus.alu_ready = w_alu_ready;
   assign bus.mem_ready = !w_full;
   assign bus.C         = r_c;
   assign bus.Caddr     = r_caddr;
   assign bus.Load      = r_load;
   assign bus.pending   = w_pending;
   assign bus.count     = r_cnt;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed checks of reset, priority, backpressure, ordering/wrap and clear
module tb_reg_writeback;
   logic clk = 1'b0;
   logic clear = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   always #5 clk = ~clk;
   reg_writeback_if #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) bus ();
   reg_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus.slave)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   initial begin
      bus.alu_valid = 1'b0;
      bus.alu_addr  = '0;
      bus.alu_data  = '0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_data  = '0;
      bus.hold      = 1'b0;
      step();
      clear = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("idle_load", 32'(bus.Load), 32'd0);
         chk("idle_c", 32'(bus.C), 32'd0);
         chk("idle_caddr", 32'(bus.Caddr), 32'd0);
         chk("idle_pending", 32'(bus.pending), 32'h0);
         chk("idle_empty", 32'(bus.empty), 32'd1);
         chk("idle_count", 32'(bus.count), 32'd0);
      end
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 4'd3;
      bus.alu_data  = 16'h00AB;
      #1;
      chk("single_alu_ready", 32'(bus.alu_ready), 32'd1);
      step();
      bus.alu_valid = 1'b0;
      chk("single_pending", 32'(bus.pending), 32'h0008);
      chk("single_count", 32'(bus.count), 32'd1);
      chk("single_load0", 32'(bus.Load), 32'd0);
      step();
      chk("single_load", 32'(bus.Load), 32'd1);
      chk("single_caddr", 32'(bus.Caddr), 32'd3);
      chk("single_c", 32'(bus.C), 32'h00AB);
      chk("single_pending_load", 32'(bus.pending), 32'h0008);
      step();
      chk("single_done_load", 32'(bus.Load), 32'd0);
      chk("single_done_pending", 32'(bus.pending), 32'h0);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 4'd5;
      bus.mem_data  = 16'h1111;
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 4'd6;
      bus.alu_data  = 16'h2222;
      #1;
      chk("prio_mem_ready", 32'(bus.mem_ready), 32'd1);
      chk("prio_alu_ready", 32'(bus.alu_ready), 32'd0);
      step();
      bus.mem_valid = 1'b0;
      #1;
      chk("prio_alu_ready2", 32'(bus.alu_ready), 32'd1);
      chk("prio_pending", 32'(bus.pending), 32'h0020);
      step();
      bus.alu_valid = 1'b0;
      chk("prio_w1_load", 32'(bus.Load), 32'd1);
      chk("prio_w1_caddr", 32'(bus.Caddr), 32'd5);
      chk("prio_w1_c", 32'(bus.C), 32'h1111);
      step();
      chk("prio_w2_load", 32'(bus.Load), 32'd1);
      chk("prio_w2_caddr", 32'(bus.Caddr), 32'd6);
      chk("prio_w2_c", 32'(bus.C), 32'h2222);
      step();
      chk("prio_idle_load", 32'(bus.Load), 32'd0);
      chk("prio_idle_empty", 32'(bus.empty), 32'd1);
      bus.hold = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 4'(k);
         bus.alu_data  = 16'h0100 + 16'(k);
         step();
         chk("fill_hold_load", 32'(bus.Load), 32'd0);
      end
      bus.alu_valid = 1'b0;
      #1;
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_count", 32'(bus.count), 32'd4);
      chk("fill_alu_ready", 32'(bus.alu_ready), 32'd0);
      chk("fill_mem_ready", 32'(bus.mem_ready), 32'd0);
      chk("fill_pending", 32'(bus.pending), 32'h001E);
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 4'd9;
      bus.alu_data  = 16'hDEAD;
      step();
      bus.alu_valid = 1'b0;
      chk("full_reject_count", 32'(bus.count), 32'd4);
      chk("full_reject_pending", 32'(bus.pending), 32'h001E);
      bus.hold = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("drain_load", 32'(bus.Load), 32'd1);
         chk("drain_caddr", 32'(bus.Caddr), 32'(k));
         chk("drain_c", 32'(bus.C), 32'h0100 + 32'(k));
         chk("drain_full", 32'(bus.full), 32'd0);
      end
      step();
      chk("drain_end_load", 32'(bus.Load), 32'd0);
      chk("drain_end_empty", 32'(bus.empty), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 4'd7;
         bus.alu_data  = 16'(k);
         step();
         chk("stream_count", 32'(bus.count), 32'd1);
         if (k > 1) begin
            chk("stream_load", 32'(bus.Load), 32'd1);
            chk("stream_c", 32'(bus.C), 32'(k - 1));
            chk("stream_caddr", 32'(bus.Caddr), 32'd7);
         end
      end
      bus.alu_valid = 1'b0;
      step();
      chk("stream_last_load", 32'(bus.Load), 32'd1);
      chk("stream_last_c", 32'(bus.C), 32'd10);
      step();
      chk("stream_end_load", 32'(bus.Load), 32'd0);
      chk("stream_end_pending", 32'(bus.pending), 32'h0);
      bus.hold = 1'b1;
      for (int k = 8; k <= 11; k++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 4'(k);
         bus.alu_data  = 16'h00A0 + 16'(k);
         step();
      end
      bus.alu_valid = 1'b0;
      bus.hold      = 1'b0;
      step();
      chk("clr_pre_load", 32'(bus.Load), 32'd1);
      chk("clr_pre_caddr", 32'(bus.Caddr), 32'd8);
      chk("clr_pre_count", 32'(bus.count), 32'd3);
      chk("clr_pre_pending", 32'(bus.pending), 32'h0F00);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_load", 32'(bus.Load), 32'd0);
      chk("clr_count", 32'(bus.count), 32'd0);
      chk("clr_pending", 32'(bus.pending), 32'h0);
      chk("clr_empty", 32'(bus.empty), 32'd1);
      chk("clr_c", 32'(bus.C), 32'd0);
      chk("clr_caddr", 32'(bus.Caddr), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("clr_after_load", 32'(bus.Load), 32'd0);
         chk("clr_after_count", 32'(bus.count), 32'd0);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
